fpall_issue_queue: RTL

Parametrised request queue and issue controller in front of the shared FPALL datapath (add/mul/sqrt/div, FP32 or packed dual-FP16). It buffers operand requests with op, format and tag, and tracks the number of operations in flight. When the format changes, it drains the datapath before reconfiguring the lanes. Operand vectors are generalised from a single 32-bit word to DATA_W bits (N x 32-bit or 2N x 16-bit lanes).

---
 rtl/fpall_issue_queue.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/fpall_issue_queue.sv
// Request FIFO and issue controller for the shared FPALL datapath. It drains in-flight ops before switching lane format.
// Optional FPALL_ISSUE_STATS_EN adds the saturating counters stat_issued and stat_drain.
module fpall_issue_queue #(
   parameter int DATA_W       = 32,
   parameter int DEPTH        = 4,
   parameter int MAX_INFLIGHT = 4,
   parameter int TAG_W        = 4
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [1:0]                        in_op,
   input  logic                              in_fmt,
   input  logic [DATA_W-1:0]                 in_a,
   input  logic [DATA_W-1:0]                 in_b,
   input  logic [TAG_W-1:0]                  in_tag,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [1:0]                        out_op,
   output logic                              out_fmt,
   output logic [DATA_W-1:0]                 out_a,
   output logic [DATA_W-1:0]                 out_b,
   output logic [TAG_W-1:0]                  out_tag,
   input  logic                              dp_done,
   output logic                              cur_fmt,
   output logic [$clog2(DEPTH+1)-1:0]        count,
   output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
`ifdef FPALL_ISSUE_STATS_EN
   output logic [15:0]                       stat_issued,
   output logic [15:0]                       stat_drain,
`endif
   output logic [1:0]                        dbg_state_o
);

   // Both ports use valid/ready: a transfer happens on a rising edge where valid and ready are both high.
   // A full queue deasserts in_ready even when a pop happens in the same cycle.

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int INF_W = $clog2(MAX_INFLIGHT + 1);
   localparam logic [1:0] OP_SQRT = 2'b10;

   typedef enum logic [1:0] {
      ST_ISSUE  = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_SWITCH = 2'd2
   } state_e;

   logic [1:0]        op_mem  [DEPTH];
   logic              fmt_mem [DEPTH];
   logic [DATA_W-1:0] a_mem   [DEPTH];
   logic [DATA_W-1:0] b_mem   [DEPTH];
   logic [TAG_W-1:0]  tag_mem [DEPTH];

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [INF_W-1:0] inflight_q, inflight_d;
   state_e           state_q;
   logic             cur_fmt_q;
   logic             push, pop, retire, head_fmt;

   assign head_fmt  = fmt_mem[rd_ptr_q];
   assign in_ready  = (count_q < CNT_W'(DEPTH));
   assign out_valid = (count_q != '0) && (state_q == ST_ISSUE) &&
                      (head_fmt == cur_fmt_q) && (inflight_q < INF_W'(MAX_INFLIGHT));
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign retire    = dp_done && (inflight_q != '0);

   assign out_op      = op_mem[rd_ptr_q];
   assign out_fmt     = head_fmt;
   assign out_a       = a_mem[rd_ptr_q];
   assign out_b       = (op_mem[rd_ptr_q] == OP_SQRT) ? '0 : b_mem[rd_ptr_q];
   assign out_tag     = tag_mem[rd_ptr_q];
   assign cur_fmt     = cur_fmt_q;
   assign count       = count_q;
   assign inflight    = inflight_q;
   assign dbg_state_o = state_q;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      inflight_d = inflight_q;
      if (push) wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (!push && pop) count_d = count_q - CNT_W'(1);
      if (pop && !retire)      inflight_d = inflight_q + INF_W'(1);
      else if (!pop && retire) inflight_d = inflight_q - INF_W'(1);
   end

   // Storage is deliberately left unreset; nothing reads it while count is zero.
   always_ff @(posedge clk) begin
      if (push) begin
         op_mem[wr_ptr_q]  <= in_op;
         fmt_mem[wr_ptr_q] <= in_fmt;
         a_mem[wr_ptr_q]   <= in_a;
         b_mem[wr_ptr_q]   <= in_b;
         tag_mem[wr_ptr_q] <= in_tag;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         inflight_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         inflight_q <= inflight_d;
      end
   end

   // Issue stalls as soon as the head's format differs. A retire in the current cycle counts toward draining.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_ISSUE;
         cur_fmt_q <= 1'b0;
      end else begin
         case (state_q)
            ST_ISSUE: if ((count_q != '0) && (head_fmt != cur_fmt_q)) state_q <= ST_DRAIN;
            ST_DRAIN: if (inflight_d == '0) begin
               cur_fmt_q <= head_fmt;
               state_q   <= ST_SWITCH;
            end
            ST_SWITCH: state_q <= ST_ISSUE;
            default:   state_q <= ST_ISSUE;
         endcase
      end
   end

`ifdef FPALL_ISSUE_STATS_EN
   logic [15:0] stat_issued_q, stat_drain_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_issued_q <= '0;
         stat_drain_q  <= '0;
      end else begin
         if (pop && (stat_issued_q != 16'hFFFF)) stat_issued_q <= stat_issued_q + 16'd1;
         if ((state_q != ST_ISSUE) && (stat_drain_q != 16'hFFFF)) stat_drain_q <= stat_drain_q + 16'd1;
      end
   end

   assign stat_issued = stat_issued_q;
   assign stat_drain  = stat_drain_q;
`endif

endmodule
